dma_rx_pkt_buffer_64: RTL and testbench



---
 rtl/dma_rx_pkt_buffer_64.sv | 173 +++++++++++++++++
 tb/tb_dma_rx_pkt_buffer_64.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_rx_pkt_buffer_64.sv
// Store-and-forward packet buffer between the 64-bit fromhost width converter and the DMA write engine.
// Whole packets are released together with a byte-length descriptor; oversize packets are dropped and counted.
module dma_rx_pkt_buffer_64 #(
    parameter int DEPTH      = 512,
    parameter int DESC_DEPTH = 16,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [63:0]      s_axis_tdata,
    input  logic [7:0]       s_axis_tkeep,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    output logic [63:0]      m_axis_tdata,
    output logic [7:0]       m_axis_tkeep,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    output logic [LEN_W-1:0] m_desc_tdata,
    output logic             m_desc_tvalid,
    input  logic             m_desc_tready,
    output logic             err_drop,
    output logic [7:0]       drop_cnt
);

    localparam int AW  = $clog2(DEPTH);
    localparam int DAW = $clog2(DESC_DEPTH);
    localparam int DW  = 73;

    localparam logic [AW:0]    PTR_ONE  = (AW+1)'(1);
    localparam logic [DAW:0]   DPTR_ONE = (DAW+1)'(1);
    localparam logic [AW-1:0]  CUR_MAX  = AW'(DEPTH - 1);

    typedef enum logic {
        RECV = 1'b0,
        DROP = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [DW-1:0]    data_mem [DEPTH];
    logic [LEN_W-1:0] desc_mem [DESC_DEPTH];

    logic [AW:0]      wr_ptr, rd_ptr, pkt_start;
    logic [AW:0]      pkt_count;
    logic [AW-1:0]    cur_beats;
    logic [LEN_W-1:0] byte_acc;
    logic [DAW:0]     dwr_ptr, drd_ptr;
    logic             ready_en;

    logic             data_full, desc_full, desc_empty;
    logic             data_wr, pkt_done, pkt_over, drop_done;
    logic             rd_fire, rd_last, desc_pop;
    logic [3:0]       beat_bytes;
    logic [LEN_W-1:0] byte_sum;
    logic [DW-1:0]    rd_entry;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign data_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign desc_full  = (dwr_ptr[DAW] != drd_ptr[DAW]) && (dwr_ptr[DAW-1:0] == drd_ptr[DAW-1:0]);
    assign desc_empty = (dwr_ptr == drd_ptr);

    assign beat_bytes = popcount8(s_axis_tkeep);
    assign byte_sum   = byte_acc + LEN_W'(beat_bytes);

    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        state_nxt     = state;
        s_axis_tready = 1'b0;
        data_wr       = 1'b0;
        pkt_done      = 1'b0;
        pkt_over      = 1'b0;
        drop_done     = 1'b0;
        unique case (state)
            RECV: begin
                s_axis_tready = ready_en && !data_full && !desc_full;
                if (s_axis_tvalid && s_axis_tready) begin
                    if (!s_axis_tlast && (cur_beats == CUR_MAX)) begin
                        pkt_over  = 1'b1;
                        state_nxt = DROP;
                    end else begin
                        data_wr  = 1'b1;
                        pkt_done = s_axis_tlast;
                    end
                end
            end
            DROP: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    drop_done = 1'b1;
                    state_nxt = RECV;
                end
            end
            default: state_nxt = RECV;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state <= RECV;
        else        state <= state_nxt;
    end

    // NOTE: storage arrays carry no reset; outputs are gated by valid so stale contents never show.
    always_ff @(posedge clk) begin
        if (data_wr)  data_mem[wr_ptr[AW-1:0]]  <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        if (pkt_done) desc_mem[dwr_ptr[DAW-1:0]] <= byte_sum;
    end

    assign rd_entry      = data_mem[rd_ptr[AW-1:0]];
    assign m_axis_tvalid = (pkt_count != '0);
    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = m_axis_tvalid ? rd_entry : '0;
    assign rd_fire       = m_axis_tvalid && m_axis_tready;
    assign rd_last       = rd_fire && m_axis_tlast;

    assign m_desc_tvalid = !desc_empty;
    assign m_desc_tdata  = m_desc_tvalid ? desc_mem[drd_ptr[DAW-1:0]] : '0;
    assign desc_pop      = m_desc_tvalid && m_desc_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pkt_start <= '0;
            pkt_count <= '0;
            cur_beats <= '0;
            byte_acc  <= '0;
            dwr_ptr   <= '0;
            drd_ptr   <= '0;
            err_drop  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            ready_en <= 1'b1;

            // An oversize packet rewinds the write side to the start of the partial packet.
            if (pkt_over)     wr_ptr <= pkt_start;
            else if (data_wr) wr_ptr <= wr_ptr + PTR_ONE;

            if (pkt_done) pkt_start <= wr_ptr + PTR_ONE;

            if (pkt_done || pkt_over) begin
                cur_beats <= '0;
                byte_acc  <= '0;
            end else if (data_wr) begin
                cur_beats <= cur_beats + AW'(1);
                byte_acc  <= byte_sum;
            end

            if (rd_fire) rd_ptr <= rd_ptr + PTR_ONE;

            if (pkt_done && !rd_last)      pkt_count <= pkt_count + PTR_ONE;
            else if (!pkt_done && rd_last) pkt_count <= pkt_count - PTR_ONE;

            if (pkt_done) dwr_ptr <= dwr_ptr + DPTR_ONE;
            if (desc_pop) drd_ptr <= drd_ptr + DPTR_ONE;

            err_drop <= drop_done;
            if (drop_done && (drop_cnt != 8'hff)) drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_dma_rx_pkt_buffer_64.sv
// Directed testbench for dma_rx_pkt_buffer_64 (DEPTH=16, DESC_DEPTH=2).
// Accepted output beats and descriptors are captured and compared against a scoreboard of sent packets.
module tb_dma_rx_pkt_buffer_64;

    localparam int DEPTH      = 16;
    localparam int DESC_DEPTH = 2;
    localparam int LEN_W      = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [63:0]      s_tdata = '0;
    logic [7:0]       s_tkeep = '0;
    logic             s_tvalid = 1'b0;
    logic             s_tlast = 1'b0;
    logic             s_axis_tready;
    logic [63:0]      m_axis_tdata;
    logic [7:0]       m_axis_tkeep;
    logic             m_axis_tvalid;
    logic             m_axis_tlast;
    logic             m_tready = 1'b0;
    logic [LEN_W-1:0] m_desc_tdata;
    logic             m_desc_tvalid;
    logic             d_tready = 1'b0;
    logic             err_drop;
    logic [7:0]       drop_cnt;

    always #5 clk = ~clk;

    dma_rx_pkt_buffer_64 #(
        .DEPTH      (DEPTH),
        .DESC_DEPTH (DESC_DEPTH),
        .LEN_W      (LEN_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_tready),
        .m_desc_tdata  (m_desc_tdata),
        .m_desc_tvalid (m_desc_tvalid),
        .m_desc_tready (d_tready),
        .err_drop      (err_drop),
        .drop_cnt      (drop_cnt)
    );

    int errors   = 0;
    int n_checks = 0;

    logic [72:0]      exp_q  [$];
    logic [LEN_W-1:0] expd_q [$];
    logic [72:0]      got_q  [$];
    int               got_cyc[$];
    logic [LEN_W-1:0] gotd_q [$];
    int               got_rd  = 0;
    int               gotd_rd = 0;
    int               cyc = 0;
    int               err_pulses = 0;
    bit               rand_done = 1'b0;

    // Handshakes are observed half a cycle before the edge that completes them.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (m_axis_tvalid && m_tready) begin
                got_q.push_back({m_axis_tlast, m_axis_tkeep, m_axis_tdata});
                got_cyc.push_back(cyc);
            end
            if (m_desc_tvalid && d_tready) gotd_q.push_back(m_desc_tdata);
            if (err_drop) err_pulses <= err_pulses + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int   waited;
        logic ready_seen;
        waited = 0;
        s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            ready_seen = s_axis_tready;
            @(posedge clk);
            #1;
            if (ready_seen) break;
            waited++;
            if (waited > 3000) begin
                n_checks++;
                assert (ready_seen === 1'b1) else begin
                    errors++;
                    $error("FAIL send_timeout: observed tready=%0b expected=1", ready_seen);
                end
                break;
            end
        end
        s_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int nbeats, input logic [7:0] last_keep, input bit keep_out, input int max_gap);
        logic [LEN_W-1:0] len;
        logic [63:0]      d;
        logic [7:0]       k;
        logic             l;
        len = '0;
        for (int i = 0; i < nbeats; i++) begin
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
            d = {$urandom, $urandom};
            l = (i == nbeats - 1);
            k = l ? last_keep : 8'hff;
            send_beat(d, k, l);
            if (keep_out) exp_q.push_back({l, k, d});
            len = len + LEN_W'($countones(k));
        end
        if (keep_out) expd_q.push_back(len);
    endtask

    task automatic drain_and_compare(input string tag);
        int waited;
        waited = 0;
        m_tready = 1'b1;
        d_tready = 1'b1;
        while (((got_q.size() - got_rd) < exp_q.size() || (gotd_q.size() - gotd_rd) < expd_q.size())
               && waited < 4000) begin
            @(posedge clk); #1;
            waited++;
        end
        repeat (3) begin @(posedge clk); #1; end
        check({tag, " beat_count"}, 128'(got_q.size() - got_rd), 128'(exp_q.size()));
        check({tag, " desc_count"}, 128'(gotd_q.size() - gotd_rd), 128'(expd_q.size()));
        while (exp_q.size() > 0 && got_rd < got_q.size()) begin
            check({tag, " beat"}, 128'(got_q[got_rd]), 128'(exp_q.pop_front()));
            got_rd++;
        end
        while (expd_q.size() > 0 && gotd_rd < gotd_q.size()) begin
            check({tag, " desc"}, 128'(gotd_q[gotd_rd]), 128'(expd_q.pop_front()));
            gotd_rd++;
        end
        exp_q.delete();
        expd_q.delete();
        got_rd  = got_q.size();
        gotd_rd = gotd_q.size();
    endtask

    initial begin
        int base;
        int err_base;
        logic [63:0] a, b, c;

        // Reset state
        #12;
        check("rst tready",   128'(s_axis_tready), 128'(0));
        check("rst m_valid",  128'(m_axis_tvalid), 128'(0));
        check("rst d_valid",  128'(m_desc_tvalid), 128'(0));
        check("rst err_drop", 128'(err_drop), 128'(0));
        check("rst drop_cnt", 128'(drop_cnt), 128'(0));
        check("rst m_data",   128'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}), 128'(0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst tready", 128'(s_axis_tready), 128'(1));

        // Test 1: 3-beat packet, 20 bytes, nothing visible until tlast accepted
        m_tready = 1'b0; d_tready = 1'b0;
        a = 64'h0011_2233_4455_6677; b = 64'h8899_aabb_ccdd_eeff; c = 64'hdead_beef_0bad_f00d;
        send_beat(a, 8'hff, 1'b0); exp_q.push_back({1'b0, 8'hff, a});
        check("t1 no_valid_b1", 128'(m_axis_tvalid), 128'(0));
        send_beat(b, 8'hff, 1'b0); exp_q.push_back({1'b0, 8'hff, b});
        check("t1 no_valid_b2", 128'(m_axis_tvalid), 128'(0));
        check("t1 no_desc_b2",  128'(m_desc_tvalid), 128'(0));
        send_beat(c, 8'h0f, 1'b1); exp_q.push_back({1'b1, 8'h0f, c});
        expd_q.push_back(16'd20);
        check("t1 m_valid",  128'(m_axis_tvalid), 128'(1));
        check("t1 d_valid",  128'(m_desc_tvalid), 128'(1));
        check("t1 d_len",    128'(m_desc_tdata), 128'(16'd20));
        check("t1 head_data", 128'(m_axis_tdata), 128'(a));
        check("t1 head_keep", 128'(m_axis_tkeep), 128'(8'hff));
        drain_and_compare("t1");

        // Test 2: 4 back-to-back 2-beat packets held, then released gap-free
        m_tready = 1'b0; d_tready = 1'b1;
        for (int p = 0; p < 4; p++) send_pkt(2, 8'hff, 1'b1, 0);
        @(posedge clk); #1;
        check("t2 m_valid_held", 128'(m_axis_tvalid), 128'(1));
        check("t2 no_beats_out", 128'(got_q.size() - got_rd), 128'(0));
        check("t2 descs_out",    128'(gotd_q.size() - gotd_rd), 128'(4));
        base = got_rd;
        drain_and_compare("t2");
        for (int i = 1; i < 8; i++) check("t2 no_gap", 128'(got_cyc[base + i] - got_cyc[base]), 128'(i));

        // Test 3: 17-beat packet dropped, following 2-beat packet intact
        m_tready = 1'b0; d_tready = 1'b1;
        err_base = err_pulses;
        for (int i = 0; i < 17; i++) send_beat({$urandom, $urandom}, 8'hff, (i == 16));
        check("t3 err_drop_pulse", 128'(err_drop), 128'(1));
        check("t3 drop_cnt",       128'(drop_cnt), 128'(1));
        check("t3 no_output",      128'(m_axis_tvalid), 128'(0));
        @(posedge clk); #1;
        check("t3 err_drop_clear", 128'(err_drop), 128'(0));
        send_pkt(2, 8'hff, 1'b1, 0);
        check("t3 single_pulse", 128'(err_pulses - err_base), 128'(1));
        drain_and_compare("t3");

        // Test 4: descriptor FIFO back-pressure
        m_tready = 1'b1; d_tready = 1'b0;
        send_pkt(1, 8'hff, 1'b1, 0);
        send_pkt(1, 8'hff, 1'b1, 0);
        check("t4 ready_low", 128'(s_axis_tready), 128'(0));
        repeat (2) begin @(posedge clk); #1; end
        check("t4 ready_still_low", 128'(s_axis_tready), 128'(0));
        d_tready = 1'b1;
        @(posedge clk); #1;
        d_tready = 1'b0;
        check("t4 ready_after_pop", 128'(s_axis_tready), 128'(1));
        send_pkt(1, 8'h0f, 1'b1, 0);
        drain_and_compare("t4");

        // Test 6: reset mid-packet with stored data
        m_tready = 1'b0; d_tready = 1'b0;
        send_pkt(1, 8'hff, 1'b0, 0);
        send_beat(64'h1111_2222_3333_4444, 8'hff, 1'b0);
        send_beat(64'h5555_6666_7777_8888, 8'hff, 1'b0);
        rst_n = 1'b0;
        #2;
        check("t6 rst tready",   128'(s_axis_tready), 128'(0));
        check("t6 rst m_valid",  128'(m_axis_tvalid), 128'(0));
        check("t6 rst d_valid",  128'(m_desc_tvalid), 128'(0));
        check("t6 rst m_data",   128'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}), 128'(0));
        check("t6 rst drop_cnt", 128'(drop_cnt), 128'(0));
        check("t6 rst err_drop", 128'(err_drop), 128'(0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("t6 post tready",  128'(s_axis_tready), 128'(1));
        check("t6 post m_valid", 128'(m_axis_tvalid), 128'(0));
        exp_q.delete(); expd_q.delete();
        got_rd = got_q.size(); gotd_rd = gotd_q.size();
        send_pkt(1, 8'h0f, 1'b1, 0);
        check("t6 d_len", 128'(m_desc_tdata), 128'(16'd4));
        drain_and_compare("t6");

        // Test 5: random traffic, 1000 packets of 1..16 beats
        fork
            begin
                for (int p = 0; p < 1000; p++)
                    send_pkt($urandom_range(1, 16), ($urandom_range(0, 1) != 0) ? 8'hff : 8'h0f, 1'b1, 2);
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    m_tready = ($urandom_range(0, 3) != 0);
                    d_tready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        drain_and_compare("t5");
        check("t5 drop_cnt", 128'(drop_cnt), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule
